// File: rtl/ram_resp_pkg.sv
// Shared types and helpers for the word-level RAM responder.
package ram_resp_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} ram_resp_state_t;

  // Width of a word index for a memory of the given depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_word_array.sv
// Word storage: asynchronous read, synchronous write, reset loads each word
// with its own byte address so untouched locations echo their address.
module ram_word_array
  import ram_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Reset fills the array with address-echo contents; otherwise commit writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= WORD_W'(i * 4);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_word_responder.sv
// RAM-side responder for the ram_req/ram_miss word protocol. Stalls the
// requester for LATENCY cycles, then completes exactly one word transfer.
// LATENCY=0 degenerates to a purely combinational memory.
module ram_word_responder
  import ram_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ram_req,
  input  logic [WORD_W-1:0] ram_addr,
  input  logic              ram_we,
  input  logic [WORD_W-1:0] ram_write_word,
  output logic [WORD_W-1:0] ram_read_word,
  output logic              ram_miss,
  output logic              ram_proto_err
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);

  logic [IDX_W-1:0]  req_idx;
  logic              unused_addr_bits;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_waddr;
  logic [IDX_W-1:0]  arr_raddr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;

  // Byte address to word index; upper bits wrap, byte-lane bits are ignored.
  assign req_idx          = ram_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{ram_addr[WORD_W-1:IDX_W+2], ram_addr[1:0]};

  ram_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock(clock),
    .reset(reset),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .raddr(arr_raddr),
    .rdata(arr_rdata)
  );

  generate
    if (LATENCY == 0) begin : g_comb
      assign arr_we        = ram_req & ram_we;
      assign arr_waddr     = req_idx;
      assign arr_raddr     = req_idx;
      assign arr_wdata     = ram_write_word;
      assign ram_read_word = (ram_req & ~ram_we) ? arr_rdata : '0;
      assign ram_miss      = 1'b0;
      assign ram_proto_err = 1'b0;
    end else begin : g_fsm
      localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

      ram_resp_state_t   state;
      logic [CNT_W-1:0]  cnt;
      logic [IDX_W-1:0]  lat_idx;
      logic              lat_we;
      logic [WORD_W-1:0] lat_wdata;
      logic              proto_err;
      logic              mismatch;

      // Write data only matters for a latched write.
      assign mismatch = (req_idx != lat_idx) || (ram_we != lat_we) ||
                        (lat_we && (ram_write_word != lat_wdata));

      // Access sequencer: latch in IDLE, count down in WAIT, complete in RESP,
      // and flag any change of a still-pending request.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state     <= IDLE;
          cnt       <= '0;
          lat_idx   <= '0;
          lat_we    <= 1'b0;
          lat_wdata <= '0;
          proto_err <= 1'b0;
        end else begin
          if ((state == WAIT || state == RESP) && ram_req && mismatch) begin
            proto_err <= 1'b1;
          end
          case (state)
            IDLE: begin
              if (ram_req) begin
                lat_idx   <= req_idx;
                lat_we    <= ram_we;
                lat_wdata <= ram_write_word;
                cnt       <= CNT_W'(LATENCY - 1);
                state     <= (LATENCY > 1) ? WAIT : RESP;
              end
            end
            WAIT: begin
              cnt <= cnt - CNT_W'(1);
              if (!ram_req) begin
                state <= IDLE;
              end else if (cnt == CNT_W'(1)) begin
                state <= RESP;
              end
            end
            RESP: begin
              state <= IDLE;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end

      assign arr_we        = (state == RESP) && lat_we;
      assign arr_waddr     = lat_idx;
      assign arr_raddr     = lat_idx;
      assign arr_wdata     = lat_wdata;
      assign ram_miss      = (state == IDLE) ? ram_req : (state == WAIT);
      assign ram_read_word = ((state == RESP) && !lat_we) ? arr_rdata : '0;
      assign ram_proto_err = proto_err;
    end
  endgenerate

endmodule

// File: tb/tb_ram_word_responder.sv
// Directed bench for ram_word_responder: one LATENCY=2 instance driven
// through reads, writes, bursts, aborts and protocol violations, plus a
// LATENCY=0 instance for the combinational path.
module tb_ram_word_responder;

  logic        clock = 1'b0;
  logic        reset;

  logic        ram_req;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_write_word;
  logic [31:0] ram_read_word;
  logic        ram_miss;
  logic        ram_proto_err;

  logic        req0;
  logic [31:0] addr0;
  logic        we0;
  logic [31:0] wdata0;
  logic [31:0] rdata0;
  logic        miss0;
  logic        err0;

  int          tests    = 0;
  int          failures = 0;
  logic [31:0] rd;
  int          stalls;

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  ram_word_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .ram_req       (ram_req),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_write_word(ram_write_word),
    .ram_read_word (ram_read_word),
    .ram_miss      (ram_miss),
    .ram_proto_err (ram_proto_err)
  );

  ram_word_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clock         (clock),
    .reset         (reset),
    .ram_req       (req0),
    .ram_addr      (addr0),
    .ram_we        (we0),
    .ram_write_word(wdata0),
    .ram_read_word (rdata0),
    .ram_miss      (miss0),
    .ram_proto_err (err0)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One complete access on the LATENCY=2 instance with a bounded wait for
  // ram_miss to drop; returns the completion data and the stall count.
  task automatic applyStimulus(input logic [31:0] addr, input logic we,
                               input logic [31:0] wdata,
                               output logic [31:0] rdata, output int nstall);
    nstall         = 0;
    rdata          = 32'hxxxx_xxxx;
    ram_req        = 1'b1;
    ram_addr       = addr;
    ram_we         = we;
    ram_write_word = wdata;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (!ram_miss) begin
        rdata = ram_read_word;
        break;
      end
      nstall++;
    end
    @(posedge clock);
    #1;
    ram_req = 1'b0;
    ram_we  = 1'b0;
  endtask

  // Linear directed sequence.
  initial begin
    reset          = 1'b1;
    ram_req        = 1'b0;
    ram_addr       = '0;
    ram_we         = 1'b0;
    ram_write_word = '0;
    req0           = 1'b0;
    addr0          = '0;
    we0            = 1'b0;
    wdata0         = '0;

    // Reset state
    @(negedge clock);
    checkOutput("rst_rd", ram_read_word, 32'h0);
    checkOutput("rst_miss", {31'b0, ram_miss}, 32'h0);
    checkOutput("rst_err", {31'b0, ram_proto_err}, 32'h0);
    checkOutput("rst_rd0", rdata0, 32'h0);
    checkOutput("rst_miss0", {31'b0, miss0}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Read 0x10, cycle by cycle: miss 1,1,0 with data only at T+2
    ram_req  = 1'b1;
    ram_addr = 32'h10;
    ram_we   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkOutput("rd10_miss", {31'b0, ram_miss}, (c < 2) ? 32'h1 : 32'h0);
      checkOutput("rd10_data", ram_read_word, (c == 2) ? 32'h10 : 32'h0);
      @(posedge clock);
      #1;
    end
    ram_req = 1'b0;
    @(negedge clock);
    checkOutput("idle_miss", {31'b0, ram_miss}, 32'h0);
    checkOutput("idle_data", ram_read_word, 32'h0);
    @(posedge clock);
    #1;

    // Write then read back
    applyStimulus(32'h20, 1'b1, 32'hDEADBEEF, rd, stalls);
    checkOutput("wr20_stalls", stalls, 32'd2);
    checkOutput("wr20_data", rd, 32'h0);
    applyStimulus(32'h20, 1'b0, 32'h0, rd, stalls);
    checkOutput("rd20_stalls", stalls, 32'd2);
    checkOutput("rd20_data", rd, 32'hDEADBEEF);

    // Glue-style 4-word burst from 0x40, completions at cycles 2,5,8,11
    ram_req  = 1'b1;
    ram_addr = 32'h40;
    ram_we   = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      checkOutput("burst_miss", {31'b0, ram_miss}, (c % 3 == 2) ? 32'h0 : 32'h1);
      checkOutput("burst_data", ram_read_word,
                  (c % 3 == 2) ? (32'h40 + 32'(4 * (c / 3))) : 32'h0);
      @(posedge clock);
      #1;
      if (c % 3 == 2) ram_addr = ram_addr + 32'd4;
    end
    ram_req = 1'b0;
    @(posedge clock);
    #1;

    // Write to 0x30 aborted in WAIT: nothing is stored
    ram_req        = 1'b1;
    ram_addr       = 32'h30;
    ram_we         = 1'b1;
    ram_write_word = 32'h1234;
    @(negedge clock);
    checkOutput("abort_miss_t", {31'b0, ram_miss}, 32'h1);
    @(posedge clock);
    #1;
    ram_req = 1'b0;
    @(negedge clock);
    checkOutput("abort_miss_wait", {31'b0, ram_miss}, 32'h1);
    @(posedge clock);
    #1;
    ram_we = 1'b0;
    @(negedge clock);
    checkOutput("abort_miss_idle", {31'b0, ram_miss}, 32'h0);
    @(posedge clock);
    #1;
    applyStimulus(32'h30, 1'b0, 32'h0, rd, stalls);
    checkOutput("rd30_data", rd, 32'h30);
    checkOutput("abort_err", {31'b0, ram_proto_err}, 32'h0);

    // Address wrap: 0x404 maps to word 1
    applyStimulus(32'h404, 1'b0, 32'h0, rd, stalls);
    checkOutput("wrap_stalls", stalls, 32'd2);
    checkOutput("wrap_data", rd, 32'h4);

    // Address changed while pending: sticky error, latched address wins
    ram_req  = 1'b1;
    ram_addr = 32'h50;
    ram_we   = 1'b0;
    @(posedge clock);
    #1;
    ram_addr = 32'h54;
    @(negedge clock);
    checkOutput("proto_err_before", {31'b0, ram_proto_err}, 32'h0);
    checkOutput("proto_miss_wait", {31'b0, ram_miss}, 32'h1);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("proto_miss_resp", {31'b0, ram_miss}, 32'h0);
    checkOutput("proto_data", ram_read_word, 32'h50);
    checkOutput("proto_err_set", {31'b0, ram_proto_err}, 32'h1);
    @(posedge clock);
    #1;
    ram_req = 1'b0;
    @(negedge clock);
    checkOutput("proto_err_sticky", {31'b0, ram_proto_err}, 32'h1);
    @(posedge clock);
    #1;

    // Reset in the middle of a write: write discarded, error cleared
    ram_req        = 1'b1;
    ram_addr       = 32'h24;
    ram_we         = 1'b1;
    ram_write_word = 32'hFFFF0000;
    @(posedge clock);
    #1;
    reset   = 1'b1;
    ram_req = 1'b0;
    ram_we  = 1'b0;
    #2;
    checkOutput("midrst_miss", {31'b0, ram_miss}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midrst_err", {31'b0, ram_proto_err}, 32'h0);
    @(posedge clock);
    #1;
    applyStimulus(32'h24, 1'b0, 32'h0, rd, stalls);
    checkOutput("midrst_rd24", rd, 32'h24);
    applyStimulus(32'h20, 1'b0, 32'h0, rd, stalls);
    checkOutput("midrst_rd20", rd, 32'h20);

    // LATENCY=0: data in the request cycle, never a stall
    req0  = 1'b1;
    addr0 = 32'h404;
    we0   = 1'b0;
    #1;
    checkOutput("l0_wrap_data", rdata0, 32'h4);
    checkOutput("l0_wrap_miss", {31'b0, miss0}, 32'h0);
    @(posedge clock);
    #1;
    addr0  = 32'h8;
    we0    = 1'b1;
    wdata0 = 32'hCAFEF00D;
    @(negedge clock);
    checkOutput("l0_wr_data", rdata0, 32'h0);
    checkOutput("l0_wr_miss", {31'b0, miss0}, 32'h0);
    @(posedge clock);
    #1;
    we0 = 1'b0;
    @(negedge clock);
    checkOutput("l0_rd_data", rdata0, 32'hCAFEF00D);
    checkOutput("l0_rd_miss", {31'b0, miss0}, 32'h0);
    @(posedge clock);
    #1;
    req0 = 1'b0;
    @(negedge clock);
    checkOutput("l0_idle_data", rdata0, 32'h0);
    checkOutput("l0_err", {31'b0, err0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
